usb_bulk_ep_router: RTL and testbench
=====================================

# usb_bulk_ep_router

Parametrised bulk-endpoint router between the transfer layer's single bulk port (the `blk_*` / `bid_*` signals of `usb_xfer`) and `NUM_EP` independent application channels. It decodes the 4-bit endpoint address and latches a channel for the duration of each bulk IN or OUT transfer. It muxes the IN AXI4-Stream and demuxes the OUT byte stream. Abandoned IN packets are drained from the channel so that stream stays packet-aligned. The block sits beside the transaction-layer top, replacing the single hard-wired bulk endpoint with `NUM_EP` endpoints.

## Interface
- `NUM_EP`, default 2: number of bulk channels, 1..15.
- `EP_BASE`, default 1: endpoint address of channel 0; channel k answers endpoint `EP_BASE+k`; `EP_BASE+NUM_EP-1` must be ≤ 15.

Ports:
- `clk` in 1: USB clock (60 MHz ULPI clock).
- `rst_n` in 1: asynchronous reset, active-low.
- `blk_xfer_endpoint_i` in 4: endpoint of current bulk transfer.
- `blk_in_xfer_i` in 1: level, high for the duration of a bulk IN transfer.
- `blk_out_xfer_i` in 1: level, high for the duration of a bulk OUT transfer.
- `bid_has_data_o` out 1: addressed channel has a full packet.
- `bid_tvalid_o` out 1, `bid_tready_i` in 1, `bid_tlast_o` out 1, `bid_tdata_o` out 8: IN stream to the transfer layer.
- `blk_out_ready_o` out 1: addressed channel can accept a max-size packet.
- `blk_out_tvalid_i` in 1, `blk_out_tdata_i` in 8: OUT bytes from the transfer layer.
- `ch_has_data_i` in NUM_EP: per-channel has-packet flags.
- `ch_in_tvalid_i` in NUM_EP, `ch_in_tready_o` out NUM_EP, `ch_in_tlast_i` in NUM_EP, `ch_in_tdata_i` in 8·NUM_EP: per-channel IN streams; channel k occupies bits [8k+7:8k].
- `ch_out_ready_i` in NUM_EP: per-channel OUT space flags.
- `ch_out_tvalid_o` out NUM_EP, `ch_out_tdata_o` out 8: OUT byte strobe per channel; the data bus is shared.
- `ch_out_end_o` out NUM_EP: one-cycle pulse at the end of an OUT transfer.
- `sel_index_o` out 4: latched channel index.
- `busy_o` out 1: state ≠ IDLE.
- `err_o` out 1: one-cycle pulse on an unknown endpoint, or on IN and OUT both high.
- `stat_in_pkts_o` out 16·NUM_EP, `stat_out_pkts_o` out 16·NUM_EP, `stat_abort_o` out 16: counters (see Configuration).

## Operation
- Decode, combinational: `hit = (ep ≥ EP_BASE) && (ep < EP_BASE+NUM_EP)`, `idx = ep − EP_BASE`, computed at 4 bits.
  - In IDLE, `bid_has_data_o = hit & ch_has_data_i[idx]` and `blk_out_ready_o = hit & ch_out_ready_i[idx]`.
  - Out of range gives 0 on both.
- State machine, states IDLE, IN_XFER, IN_DRAIN, OUT_XFER.
- IDLE → IN_XFER: `blk_in_xfer_i` high and `hit`; latch `sel_index_o = idx`.
- IDLE → OUT_XFER: `blk_out_xfer_i` high, `blk_in_xfer_i` low, and `hit`; latch `sel_index_o = idx`.
- IDLE with an xfer level high and `!hit`:
  - pulse `err_o` once per assertion;
  - stay in IDLE;
  - all channel strobes stay 0.
- IN and OUT levels both high in IDLE: IN wins and `err_o` pulses.
- IN_XFER datapath:
  - `bid_*` come from channel `sel_index_o`;
  - `ch_in_tready_o[sel] = bid_tready_i`;
  - all other `ch_in_tready_o` bits are 0.
- IN_XFER exits:
  - handshake with `tlast` and `blk_in_xfer_i` still high → IDLE (packet complete);
  - `blk_in_xfer_i` falls before the `tlast` handshake → IN_DRAIN, with `bid_tvalid_o` forced to 0 from that cycle.
- IN_DRAIN:
  - `ch_in_tready_o[sel] = 1`, discarding bytes;
  - on the `tvalid & tlast` beat → IDLE and increment the abort counter.
- OUT_XFER:
  - `ch_out_tvalid_o[sel] = blk_out_tvalid_i`;
  - `ch_out_tdata_o = blk_out_tdata_i`;
  - when `blk_out_xfer_i` falls → IDLE and pulse `ch_out_end_o[sel]` for one cycle.
- `ch_out_tdata_o` carries `blk_out_tdata_i` at all times; it is only qualified by `ch_out_tvalid_o`.

## Timing
- Selection is registered: the first cycle an xfer level is high, the state is still IDLE, so `bid_tvalid_o = 0` and no OUT strobe is forwarded.
  - The transfer layer does not present OUT bytes or sample IN bytes in that cycle.
- Data paths have 0-cycle latency once selected (pure mux, no buffering).
- `ch_out_end_o` is asserted in the cycle after the falling edge of `blk_out_xfer_i` is seen.
- Reset values:
  - state IDLE;
  - `sel_index_o = 0`;
  - `busy_o`, `err_o`, `ch_out_end_o`, all strobes and all counters 0.
- Reset asserted mid-transfer: asynchronous return to IDLE; a partially drained channel is not drained further.
- A new xfer level seen in the same cycle as the IN_XFER/IN_DRAIN/OUT_XFER → IDLE transition is not accepted until the next cycle in IDLE.

## Configuration
- `USB_EP_ROUTER_STATS_EN` defined:
  - `stat_in_pkts_o[k]` increments on each completed `tlast` handshake on channel k;
  - `stat_out_pkts_o[k]` increments on each `ch_out_end_o[k]`;
  - `stat_abort_o` increments on each IN_DRAIN exit;
  - all counters are 16-bit and saturate at 0xFFFF.
- Not defined: every `stat_*` output is tied to 0 and no counter flops exist.

## Test plan
- NUM_EP=2, EP_BASE=1:
  - Stimulus: ep=2, IN, 4-byte packet 0xA0..0xA3 on channel 1.
  - Response: `bid_tdata_o` delivers A0..A3 with `tlast` on A3; `ch_in_tready_o = 2'b10`; `stat_in_pkts_o[1] = 1`.
- OUT to ep=1:
  - Stimulus: 3 bytes 0x11, 0x22, 0x33, then `blk_out_xfer_i` falls.
  - Response: three `ch_out_tvalid_o[0]` strobes with matching data; `ch_out_end_o = 2'b01` for one cycle.
- Abort:
  - Stimulus: ep=1, IN, 8-byte packet; `blk_in_xfer_i` drops after 3 handshakes.
  - Response: `bid_tvalid_o = 0` from the next cycle; remaining 5 bytes drained; `stat_abort_o = 1`; IDLE.
- Unknown endpoint:
  - Stimulus: ep=5, IN.
  - Response: `err_o` pulses once; `bid_has_data_o = 0`; no `ch_in_tready_o`; `busy_o` stays 0.
- Reset mid-OUT:
  - Stimulus: `rst_n` low during OUT_XFER.
  - Response: `ch_out_tvalid_o = 0` and state IDLE immediately; no `ch_out_end_o`; counters 0.

Source files
------------

// File: rtl/usb_bulk_ep_router.sv
// rtl/usb_bulk_ep_router.sv - routes the single bulk port of usb_xfer to NUM_EP application channels
// Optional statistics counters are built when USB_EP_ROUTER_STATS_EN is defined.
module usb_bulk_ep_router #(
   parameter int NUM_EP  = 2,
   parameter int EP_BASE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [3:0]           blk_xfer_endpoint_i,
   input  logic                 blk_in_xfer_i,
   input  logic                 blk_out_xfer_i,
   output logic                 bid_has_data_o,
   output logic                 bid_tvalid_o,
   input  logic                 bid_tready_i,
   output logic                 bid_tlast_o,
   output logic [7:0]           bid_tdata_o,
   output logic                 blk_out_ready_o,
   input  logic                 blk_out_tvalid_i,
   input  logic [7:0]           blk_out_tdata_i,
   input  logic [NUM_EP-1:0]    ch_has_data_i,
   input  logic [NUM_EP-1:0]    ch_in_tvalid_i,
   output logic [NUM_EP-1:0]    ch_in_tready_o,
   input  logic [NUM_EP-1:0]    ch_in_tlast_i,
   input  logic [8*NUM_EP-1:0]  ch_in_tdata_i,
   input  logic [NUM_EP-1:0]    ch_out_ready_i,
   output logic [NUM_EP-1:0]    ch_out_tvalid_o,
   output logic [7:0]           ch_out_tdata_o,
   output logic [NUM_EP-1:0]    ch_out_end_o,
   output logic [3:0]           sel_index_o,
   output logic                 busy_o,
   output logic                 err_o,
   output logic [16*NUM_EP-1:0] stat_in_pkts_o,
   output logic [16*NUM_EP-1:0] stat_out_pkts_o,
   output logic [15:0]          stat_abort_o
);
   typedef enum logic [1:0] {IDLE, IN_XFER, IN_DRAIN, OUT_XFER} state_t;
   state_t state, state_nxt;

   logic              hit;
   logic [3:0]        idx;
   logic [3:0]        ch;
   logic [NUM_EP-1:0] sel_onehot;
   logic              c_has, c_ready, c_valid, c_last;
   logic [7:0]        c_data;
   logic              err_cond, err_armed;
   logic              in_done, abort_done, out_done;

   assign hit = ({1'b0, blk_xfer_endpoint_i} >= 5'(EP_BASE)) &&
                ({1'b0, blk_xfer_endpoint_i} <  5'(EP_BASE + NUM_EP));
   assign idx = blk_xfer_endpoint_i - 4'(EP_BASE);

   // In IDLE the live decode drives the mux, otherwise the latched channel.
   assign ch = (state == IDLE) ? idx : sel_index_o;

   always_comb begin
      c_has      = 1'b0;
      c_ready    = 1'b0;
      c_valid    = 1'b0;
      c_last     = 1'b0;
      c_data     = '0;
      sel_onehot = '0;
      for (int k = 0; k < NUM_EP; k++) begin
         sel_onehot[k] = (sel_index_o == 4'(k));
         if (ch == 4'(k)) begin
            c_has   = ch_has_data_i[k];
            c_ready = ch_out_ready_i[k];
            c_valid = ch_in_tvalid_i[k];
            c_last  = ch_in_tlast_i[k];
            c_data  = ch_in_tdata_i[8*k +: 8];
         end
      end
   end

   assign bid_has_data_o  = (state == IDLE) ? (hit & c_has) : c_has;
   assign blk_out_ready_o = (state == IDLE) ? (hit & c_ready) : c_ready;
   assign bid_tdata_o     = c_data;
   assign bid_tlast_o     = c_last;
   assign ch_out_tdata_o  = blk_out_tdata_i;
   assign busy_o          = (state != IDLE);
   assign err_cond        = (state == IDLE) && (blk_in_xfer_i || blk_out_xfer_i) &&
                            (!hit || (blk_in_xfer_i && blk_out_xfer_i));

   always_comb begin
      state_nxt       = state;
      bid_tvalid_o    = 1'b0;
      ch_in_tready_o  = '0;
      ch_out_tvalid_o = '0;
      in_done         = 1'b0;
      abort_done      = 1'b0;
      out_done        = 1'b0;
      case (state)
         IDLE: begin
            if (blk_in_xfer_i && hit)
               state_nxt = IN_XFER;
            else if (blk_out_xfer_i && hit)
               state_nxt = OUT_XFER;
         end
         IN_XFER: begin
            // Once the host abandons the packet nothing more is presented or consumed here.
            if (blk_in_xfer_i) begin
               bid_tvalid_o   = c_valid;
               ch_in_tready_o = sel_onehot & {NUM_EP{bid_tready_i}};
               if (c_valid && bid_tready_i && c_last) begin
                  state_nxt = IDLE;
                  in_done   = 1'b1;
               end
            end else begin
               state_nxt = IN_DRAIN;
            end
         end
         IN_DRAIN: begin
            ch_in_tready_o = sel_onehot;
            if (c_valid && c_last) begin
               state_nxt  = IDLE;
               abort_done = 1'b1;
            end
         end
         OUT_XFER: begin
            ch_out_tvalid_o = sel_onehot & {NUM_EP{blk_out_tvalid_i}};
            if (!blk_out_xfer_i) begin
               state_nxt = IDLE;
               out_done  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         sel_index_o  <= '0;
         err_o        <= 1'b0;
         err_armed    <= 1'b0;
         ch_out_end_o <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && state_nxt != IDLE)
            sel_index_o <= idx;
         err_o <= err_cond && !err_armed;
         // One error pulse per level assertion; re-arm only once both levels are low.
         if (err_cond)
            err_armed <= 1'b1;
         else if (!blk_in_xfer_i && !blk_out_xfer_i)
            err_armed <= 1'b0;
         ch_out_end_o <= out_done ? sel_onehot : '0;
      end
   end

`ifdef USB_EP_ROUTER_STATS_EN
   logic [15:0] in_cnt  [NUM_EP];
   logic [15:0] out_cnt [NUM_EP];
   logic [15:0] abort_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_EP; k++) begin
            in_cnt[k]  <= '0;
            out_cnt[k] <= '0;
         end
         abort_cnt <= '0;
      end else begin
         for (int k = 0; k < NUM_EP; k++) begin
            if (in_done && sel_onehot[k] && in_cnt[k] != 16'hFFFF)
               in_cnt[k] <= in_cnt[k] + 16'd1;
            if (out_done && sel_onehot[k] && out_cnt[k] != 16'hFFFF)
               out_cnt[k] <= out_cnt[k] + 16'd1;
         end
         if (abort_done && abort_cnt != 16'hFFFF)
            abort_cnt <= abort_cnt + 16'd1;
      end
   end

   always_comb begin
      stat_in_pkts_o  = '0;
      stat_out_pkts_o = '0;
      for (int k = 0; k < NUM_EP; k++) begin
         stat_in_pkts_o[16*k +: 16]  = in_cnt[k];
         stat_out_pkts_o[16*k +: 16] = out_cnt[k];
      end
   end
   assign stat_abort_o = abort_cnt;
`else
   logic unused_stats;
   assign unused_stats    = in_done | abort_done;
   assign stat_in_pkts_o  = '0;
   assign stat_out_pkts_o = '0;
   assign stat_abort_o    = '0;
`endif
endmodule

// File: tb/tb_usb_bulk_ep_router.sv
// tb/tb_usb_bulk_ep_router.sv - randomized self-checking bench for usb_bulk_ep_router
// Expected statistics follow USB_EP_ROUTER_STATS_EN when it is defined for the build.
module tb_usb_bulk_ep_router;
   localparam int N    = 2;
   localparam int BASE = 1;
`ifdef USB_EP_ROUTER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    ep = '0;
   logic          in_x = 1'b0, out_x = 1'b0, tready = 1'b0;
   logic          o_tvalid = 1'b0;
   logic [7:0]    o_tdata = '0;
   logic [N-1:0]  ch_has = '0, ch_tvalid = '0, ch_tlast = '0, ch_oready = '0;
   logic [8*N-1:0] ch_tdata = '0;
   logic          has_data, bid_tvalid, bid_tlast, out_ready, busy, err;
   logic [7:0]    bid_tdata, ch_otdata;
   logic [N-1:0]  ch_tready, ch_otvalid, ch_oend;
   logic [3:0]    sel;
   logic [16*N-1:0] st_in, st_out;
   logic [15:0]   st_abort;

   always #5 clk = ~clk;

   usb_bulk_ep_router #(.NUM_EP(N), .EP_BASE(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .blk_xfer_endpoint_i(ep),
      .blk_in_xfer_i(in_x), .blk_out_xfer_i(out_x),
      .bid_has_data_o(has_data), .bid_tvalid_o(bid_tvalid), .bid_tready_i(tready),
      .bid_tlast_o(bid_tlast), .bid_tdata_o(bid_tdata), .blk_out_ready_o(out_ready),
      .blk_out_tvalid_i(o_tvalid), .blk_out_tdata_i(o_tdata),
      .ch_has_data_i(ch_has), .ch_in_tvalid_i(ch_tvalid), .ch_in_tready_o(ch_tready),
      .ch_in_tlast_i(ch_tlast), .ch_in_tdata_i(ch_tdata), .ch_out_ready_i(ch_oready),
      .ch_out_tvalid_o(ch_otvalid), .ch_out_tdata_o(ch_otdata), .ch_out_end_o(ch_oend),
      .sel_index_o(sel), .busy_o(busy), .err_o(err),
      .stat_in_pkts_o(st_in), .stat_out_pkts_o(st_out), .stat_abort_o(st_abort));

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Channel-side packet sources: {tlast, data} per entry.
   logic [8:0] cbuf [N][1024];
   int crd [N];
   int cwr [N];
   logic [N-1:0] pop = '0;

   task automatic drive_ch();
      for (int k = 0; k < N; k++) begin
         ch_tvalid[k]          = (crd[k] != cwr[k]);
         ch_has[k]             = (crd[k] != cwr[k]);
         ch_tlast[k]           = cbuf[k][crd[k]][8];
         ch_tdata[8*k +: 8]    = cbuf[k][crd[k]][7:0];
      end
   endtask

   task automatic push_pkt(input int k, input int len, input logic [7:0] first);
      for (int i = 0; i < len; i++) begin
         cbuf[k][cwr[k]] = {(i == len - 1), first + 8'(i)};
         cwr[k]++;
      end
   endtask

   // Reference model state.
   int m_mode;     // 0 idle, 1 forwarding IN, 2 draining IN, 3 forwarding OUT
   int m_sel, m_end, m_abort;
   int m_in [N];
   int m_out [N];
   bit m_err, m_err_seen;

   task automatic model_reset();
      m_mode = 0; m_sel = 0; m_end = -1; m_abort = 0; m_err = 0; m_err_seen = 0;
      for (int k = 0; k < N; k++) begin m_in[k] = 0; m_out[k] = 0; end
   endtask

   function automatic int sat(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   task automatic model_step();
      bit hit, cond;
      int e;
      e    = int'(ep);
      hit  = (e >= BASE) && (e < BASE + N);
      cond = (m_mode == 0) && (in_x || out_x) && (!hit || (in_x && out_x));
      m_end = -1;
      m_err = cond && !m_err_seen;
      case (m_mode)
         0: if (in_x && hit) begin m_mode = 1; m_sel = e - BASE; end
            else if (out_x && hit) begin m_mode = 3; m_sel = e - BASE; end
         1: if (!in_x) m_mode = 2;
            else if (ch_tvalid[m_sel] && tready && ch_tlast[m_sel]) begin
               m_mode = 0; m_in[m_sel] = sat(m_in[m_sel]);
            end
         2: if (ch_tvalid[m_sel] && ch_tlast[m_sel]) begin m_mode = 0; m_abort = sat(m_abort); end
         3: if (!out_x) begin m_mode = 0; m_end = m_sel; m_out[m_sel] = sat(m_out[m_sel]); end
         default: m_mode = 0;
      endcase
      if (cond) m_err_seen = 1;
      else if (!in_x && !out_x) m_err_seen = 0;
   endtask

   // Observations for the directed scenarios.
   logic [31:0] obs_bid;
   logic [23:0] obs_out0;
   logic [N-1:0] obs_tready_or, obs_end_v;
   int obs_bid_n, obs_last_n, obs_out0_n, obs_end_n, obs_err_n, obs_tv_low, obs_pop0;
   bit obs_busy, obs_has;
   bit hs_flag, hs_last_flag;

   task automatic clear_obs();
      obs_bid = '0; obs_out0 = '0; obs_tready_or = '0; obs_end_v = '0;
      obs_bid_n = 0; obs_last_n = 0; obs_out0_n = 0; obs_end_n = 0; obs_err_n = 0;
      obs_tv_low = 0; obs_pop0 = 0; obs_busy = 0; obs_has = 0;
   endtask

   always @(negedge clk) begin
      bit hit;
      int e;
      logic [N-1:0] exp_tr, exp_otv;
      bit exp_tv;
      if (!rst_n) model_reset();
      e      = int'(ep);
      hit    = (e >= BASE) && (e < BASE + N);
      exp_tv = (m_mode == 1) && in_x && ch_tvalid[m_sel];
      exp_tr = '0;
      if (m_mode == 1 && in_x && tready) exp_tr[m_sel] = 1'b1;
      if (m_mode == 2) exp_tr[m_sel] = 1'b1;
      exp_otv = '0;
      if (m_mode == 3 && o_tvalid) exp_otv[m_sel] = 1'b1;
      check("busy", busy, (m_mode != 0));
      check("sel_index", sel, m_sel);
      check("err", err, m_err);
      check("ch_out_end", ch_oend, (m_end >= 0) ? (1 << m_end) : 0);
      check("bid_tvalid", bid_tvalid, exp_tv);
      check("ch_in_tready", ch_tready, exp_tr);
      check("ch_out_tvalid", ch_otvalid, exp_otv);
      check("ch_out_tdata", ch_otdata, o_tdata);
      if (m_mode == 0) begin
         check("bid_has_data", has_data, hit ? ch_has[e - BASE] : 1'b0);
         check("blk_out_ready", out_ready, hit ? ch_oready[e - BASE] : 1'b0);
      end
      if (exp_tv) begin
         check("bid_tdata", bid_tdata, cbuf[m_sel][crd[m_sel]][7:0]);
         check("bid_tlast", bid_tlast, cbuf[m_sel][crd[m_sel]][8]);
      end
      for (int k = 0; k < N; k++) begin
         check("stat_in", st_in[16*k +: 16], STATS ? m_in[k] : 0);
         check("stat_out", st_out[16*k +: 16], STATS ? m_out[k] : 0);
      end
      check("stat_abort", st_abort, STATS ? m_abort : 0);

      pop          = ch_tvalid & ch_tready;
      hs_flag      = bid_tvalid && tready;
      hs_last_flag = hs_flag && bid_tlast;
      if (rst_n) begin
         if (hs_flag) begin
            obs_bid_n++;
            obs_bid = {obs_bid[23:0], bid_tdata};
            if (bid_tlast) obs_last_n = obs_bid_n;
         end
         obs_tready_or = obs_tready_or | ch_tready;
         if (ch_otvalid[0]) begin obs_out0 = {obs_out0[15:0], ch_otdata}; obs_out0_n++; end
         if (ch_oend != '0) begin obs_end_n++; obs_end_v = ch_oend; end
         if (err) obs_err_n++;
         if (busy) obs_busy = 1;
         if (has_data) obs_has = 1;
         if (bid_tvalid && !in_x) obs_tv_low++;
         if (pop[0]) obs_pop0++;
         model_step();
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) if (pop[k]) crd[k]++;
      drive_ch();
      ch_oready = N'($urandom);
   endtask

   task automatic rand_in();
      int e, len, drop, hs;
      bit abort_it, done, hit;
      e        = $urandom_range(0, 4);
      len      = $urandom_range(1, 8);
      drop     = $urandom_range(0, len - 1);
      abort_it = ($urandom_range(0, 2) == 0);
      hit      = (e >= BASE) && (e < BASE + N);
      if (hit) push_pkt(e - BASE, len, 8'($urandom));
      drive_ch();
      ep = 4'(e); in_x = 1'b1; out_x = ($urandom_range(0, 4) == 0);
      hs = 0; done = 0;
      for (int c = 0; c < 100 && !done; c++) begin
         tready = ($urandom_range(0, 3) != 0);
         step();
         if (hs_flag) hs++;
         if (hs_last_flag || (abort_it && hs == drop) || (!hit && c == 3)) done = 1;
      end
      check("rand_in_done", done, 1'b1);
      in_x = 1'b0; out_x = 1'b0;
      for (int c = 0; c < 60 && busy; c++) step();
      check("rand_in_idle", busy, 1'b0);
      step();
   endtask

   task automatic rand_out();
      int n;
      ep = 4'($urandom_range(0, 4)); out_x = 1'b1; o_tvalid = 1'b0;
      n = $urandom_range(0, 6);
      step();
      for (int i = 0; i < n; i++) begin
         o_tvalid = 1'($urandom);
         o_tdata  = 8'($urandom);
         step();
      end
      out_x = 1'b0; o_tvalid = 1'b0;
      step(); step();
      check("rand_out_idle", busy, 1'b0);
   endtask

   initial begin
      int hs;
      for (int k = 0; k < N; k++) begin
         crd[k] = 0; cwr[k] = 0;
         for (int i = 0; i < 1024; i++) cbuf[k][i] = '0;
      end
      model_reset();
      clear_obs();
      drive_ch();
      step(); step();
      check("rst_busy", busy, 1'b0);
      check("rst_sel", sel, 4'd0);
      check("rst_err", err, 1'b0);
      check("rst_end", ch_oend, 2'b00);
      check("rst_stats", {st_in, st_out, st_abort}, 80'd0);
      rst_n = 1'b1;
      step();

      // IN on ep 2: channel 1 packet A0..A3.
      clear_obs();
      push_pkt(1, 4, 8'hA0); drive_ch();
      ep = 4'd2; in_x = 1'b1; tready = 1'b1;
      for (int c = 0; c < 50; c++) begin step(); if (hs_last_flag) break; end
      in_x = 1'b0;
      step(); step();
      check("in_bytes", obs_bid, 32'hA0A1A2A3);
      check("in_count", obs_bid_n, 4);
      check("in_tlast_pos", obs_last_n, 4);
      check("in_tready_ch", obs_tready_or, 2'b10);
      check("in_stat", st_in[31:16], STATS ? 16'd1 : 16'd0);

      // OUT on ep 1: 11 22 33.
      clear_obs();
      ep = 4'd1; out_x = 1'b1; o_tvalid = 1'b0;
      step();
      o_tvalid = 1'b1; o_tdata = 8'h11; step();
      o_tdata = 8'h22; step();
      o_tdata = 8'h33; step();
      o_tvalid = 1'b0; out_x = 1'b0;
      step(); step(); step();
      check("out_bytes", obs_out0, 24'h112233);
      check("out_count", obs_out0_n, 3);
      check("out_end_count", obs_end_n, 1);
      check("out_end_ch", obs_end_v, 2'b01);
      check("out_stat", st_out[15:0], STATS ? 16'd1 : 16'd0);

      // Abort on ep 1 after 3 of 8 bytes.
      clear_obs();
      push_pkt(0, 8, 8'hB0); drive_ch();
      ep = 4'd1; in_x = 1'b1; tready = 1'b1; hs = 0;
      for (int c = 0; c < 50 && hs < 3; c++) begin step(); if (hs_flag) hs++; end
      in_x = 1'b0;
      for (int c = 0; c < 50; c++) begin step(); if (!busy) break; end
      step();
      check("abort_bytes", obs_bid[23:0], 24'hB0B1B2);
      check("abort_hs", obs_bid_n, 3);
      check("abort_tvalid_low", obs_tv_low, 0);
      check("abort_drained", obs_pop0, 8);
      check("abort_idle", busy, 1'b0);
      check("abort_stat", st_abort, STATS ? 16'd1 : 16'd0);

      // Unknown endpoint 5.
      clear_obs();
      push_pkt(0, 2, 8'hC0); drive_ch();
      ep = 4'd5; in_x = 1'b1;
      step(); step(); step(); step();
      in_x = 1'b0;
      step(); step();
      check("unk_err_pulses", obs_err_n, 1);
      check("unk_busy", obs_busy, 1'b0);
      check("unk_tready", obs_tready_or, 2'b00);
      check("unk_has_data", obs_has, 1'b0);

      // Reset in the middle of an OUT transfer.
      ep = 4'd1; out_x = 1'b1;
      step();
      o_tvalid = 1'b1; o_tdata = 8'h55; step();
      step();
      clear_obs();
      rst_n = 1'b0;
      #2;
      check("rst_out_tvalid", ch_otvalid, 2'b00);
      check("rst_out_busy", busy, 1'b0);
      check("rst_out_end", ch_oend, 2'b00);
      check("rst_out_stats", {st_in, st_out, st_abort}, 80'd0);
      out_x = 1'b0; o_tvalid = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step(); step(); step();
      check("rst_out_no_end", obs_end_n, 0);

      for (int s = 0; s < 80; s++) begin
         if ($urandom_range(0, 1) == 0) rand_in();
         else rand_out();
         ep = 4'($urandom_range(0, 15));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end
endmodule
